// File: rtl/c5315_alu_core_if.sv
// Operand/result bundle for c5315_alu_core.
// C5315_PARITY_CHECK_EN adds the operand parity inputs and the par_err flag.
interface c5315_alu_core_if #(
  parameter int WIDTH = 9
);
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic [1:0]       arith_sel;
  logic [1:0]       logic_sel;
  logic [WIDTH-1:0] arith_out;
  logic             cout;
  logic [WIDTH-1:0] logic_out;
  logic             arith_par;
  logic             logic_par;
  logic             zero;
`ifdef C5315_PARITY_CHECK_EN
  logic             a_par_in;
  logic             b_par_in;
  logic             par_err;
`endif

  modport master (
`ifdef C5315_PARITY_CHECK_EN
    output a_par_in, b_par_in,
    input  par_err,
`endif
    output a_in, b_in, cin, arith_sel, logic_sel,
    input  arith_out, cout, logic_out, arith_par, logic_par, zero
  );

  modport slave (
`ifdef C5315_PARITY_CHECK_EN
    input  a_par_in, b_par_in,
    output par_err,
`endif
    input  a_in, b_in, cin, arith_sel, logic_sel,
    output arith_out, cout, logic_out, arith_par, logic_par, zero
  );
endinterface

// File: rtl/c5315_alu_core.sv
// Registered ALU: parallel arithmetic and logic units, result parity and zero flag.
// Optional operand parity checking is enabled with C5315_PARITY_CHECK_EN.
module c5315_alu_core #(
  parameter int WIDTH = 9
) (
  input logic              clk,
  input logic              rst,
  c5315_alu_core_if.slave  bus
);
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_term;
  logic [WIDTH:0]   cin_ext;
  logic [WIDTH:0]   sum_next;
  logic [WIDTH-1:0] logic_next;

  logic [WIDTH-1:0] arith_out_reg;
  logic             cout_reg;
  logic [WIDTH-1:0] logic_out_reg;
  logic             arith_par_reg;
  logic             logic_par_reg;
  logic             zero_reg;

  assign a_ext   = {1'b0, bus.a_in};
  assign cin_ext = {{WIDTH{1'b0}}, bus.cin};

  // Every arithmetic op is a + (selected second term) + cin at WIDTH+1 bits.
  always_comb begin
    b_term = '0;
    case (bus.arith_sel)
      2'b00:   b_term = {1'b0, bus.b_in};
      2'b01:   b_term = {1'b0, ~bus.b_in};
      2'b10:   b_term = '0;
      default: b_term = {1'b0, {WIDTH{1'b1}}};
    endcase
  end

  assign sum_next = a_ext + b_term + cin_ext;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_logic_bit
      assign logic_next[gi] =
        (bus.logic_sel == 2'b00) ? (bus.a_in[gi] & bus.b_in[gi]) :
        (bus.logic_sel == 2'b01) ? (bus.a_in[gi] | bus.b_in[gi]) :
        (bus.logic_sel == 2'b10) ? (bus.a_in[gi] ^ bus.b_in[gi]) :
                                   ~bus.a_in[gi];
    end
  endgenerate

  // Flags derive from the next-state values so they line up with the results.
  always_ff @(posedge clk) begin
    if (rst) begin
      arith_out_reg <= '0;
      cout_reg      <= 1'b0;
      logic_out_reg <= '0;
      arith_par_reg <= 1'b0;
      logic_par_reg <= 1'b0;
      zero_reg      <= 1'b0;
    end else begin
      arith_out_reg <= sum_next[WIDTH-1:0];
      cout_reg      <= sum_next[WIDTH];
      logic_out_reg <= logic_next;
      arith_par_reg <= ^sum_next[WIDTH-1:0];
      logic_par_reg <= ^logic_next;
      zero_reg      <= (sum_next[WIDTH-1:0] == '0);
    end
  end

  assign bus.arith_out = arith_out_reg;
  assign bus.cout      = cout_reg;
  assign bus.logic_out = logic_out_reg;
  assign bus.arith_par = arith_par_reg;
  assign bus.logic_par = logic_par_reg;
  assign bus.zero      = zero_reg;

`ifdef C5315_PARITY_CHECK_EN
  logic par_err_reg;

  // Results are still registered on a parity error; the flag is advisory.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_reg <= 1'b0;
    end else begin
      par_err_reg <= (^{bus.a_in, bus.a_par_in}) | (^{bus.b_in, bus.b_par_in});
    end
  end

  assign bus.par_err = par_err_reg;
`endif
endmodule

// File: tb/tb_c5315_alu_core.sv
// Randomized self-checking bench for c5315_alu_core with an arithmetic reference model.
// Build with C5315_PARITY_CHECK_EN to exercise the optional parity checker too.
module tb_c5315_alu_core;
  localparam int WIDTH = 9;
  localparam int M     = 1 << WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0] ao;
    logic             co;
    logic [WIDTH-1:0] lo;
    logic             ap;
    logic             lp;
    logic             z;
    logic             pe;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  res_t exp_q;
  bit   exp_valid = 1'b0;

  always #5 clk = ~clk;

  c5315_alu_core_if #(.WIDTH(WIDTH)) bus ();
  c5315_alu_core #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t model();
    res_t r;
    int a, b, s, l;
    a = int'(bus.a_in);
    b = int'(bus.b_in);
    case (bus.arith_sel)
      2'd0:    s = a + b + int'(bus.cin);
      2'd1:    s = a + (M - 1 - b) + int'(bus.cin);
      2'd2:    s = a + int'(bus.cin);
      default: s = a + (M - 1) + int'(bus.cin);
    endcase
    case (bus.logic_sel)
      2'd0:    l = a & b;
      2'd1:    l = a | b;
      2'd2:    l = a ^ b;
      default: l = (M - 1) - a;
    endcase
    r.ao = WIDTH'(s % M);
    r.co = (s >= M);
    r.lo = WIDTH'(l);
    r.ap = ($countones(s % M) % 2) == 1;
    r.lp = ($countones(l) % 2) == 1;
    r.z  = (s % M) == 0;
`ifdef C5315_PARITY_CHECK_EN
    r.pe = (($countones(a) + int'(bus.a_par_in)) % 2 == 1) ||
           (($countones(b) + int'(bus.b_par_in)) % 2 == 1);
`else
    r.pe = 1'b0;
`endif
    return r;
  endfunction

  function automatic res_t observe();
    res_t r;
    r.ao = bus.arith_out;
    r.co = bus.cout;
    r.lo = bus.logic_out;
    r.ap = bus.arith_par;
    r.lp = bus.logic_par;
    r.z  = bus.zero;
`ifdef C5315_PARITY_CHECK_EN
    r.pe = bus.par_err;
`else
    r.pe = 1'b0;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    exp_q     <= rst ? '0 : model();
    exp_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      res_t got;
      got = observe();
      total++;
      if (got !== exp_q) begin
        bad++;
        $display("FAIL cycle_check t=%0t got=%h want=%h", $time, got, exp_q);
      end
    end
  end

  task automatic check_lit(input string name, input res_t want);
    res_t got;
    got = observe();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end else begin
      $display("ok %s value=%h", name, got);
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic [1:0] as, input logic [1:0] ls);
    bus.a_in      = a;
    bus.b_in      = b;
    bus.cin       = c;
    bus.arith_sel = as;
    bus.logic_sel = ls;
`ifdef C5315_PARITY_CHECK_EN
    bus.a_par_in  = ^a;
    bus.b_par_in  = ^b;
`endif
    @(negedge clk);
  endtask

  task automatic drive_rand();
    drive(WIDTH'($urandom_range(M - 1)), WIDTH'($urandom_range(M - 1)),
          1'($urandom_range(1)), 2'($urandom_range(3)), 2'($urandom_range(3)));
`ifdef C5315_PARITY_CHECK_EN
    if ($urandom_range(3) == 0) bus.a_par_in = ~bus.a_par_in;
`endif
  endtask

  initial begin
    rst = 1'b1;
    drive_rand();
    drive_rand();
    check_lit("reset_zero", '0);

    rst = 1'b0;
    drive(9'h003, 9'h004, 1'b0, 2'b00, 2'b10);
    check_lit("add_xor", '{ao: 9'h007, co: 1'b0, lo: 9'h007, ap: 1'b1, lp: 1'b1, z: 1'b0, pe: 1'b0});
    drive(9'h1FF, 9'h001, 1'b0, 2'b00, 2'b00);
    check_lit("add_overflow", '{ao: 9'h000, co: 1'b1, lo: 9'h001, ap: 1'b0, lp: 1'b1, z: 1'b1, pe: 1'b0});
    drive(9'h005, 9'h003, 1'b1, 2'b01, 2'b00);
    check_lit("sub_5_3", '{ao: 9'h002, co: 1'b1, lo: 9'h001, ap: 1'b1, lp: 1'b1, z: 1'b0, pe: 1'b0});
    drive(9'h003, 9'h005, 1'b1, 2'b01, 2'b00);
    check_lit("sub_3_5", '{ao: 9'h1FE, co: 1'b0, lo: 9'h001, ap: 1'b0, lp: 1'b1, z: 1'b0, pe: 1'b0});
    drive(9'h000, 9'h0A5, 1'b0, 2'b11, 2'b11);
    check_lit("dec_inv", '{ao: 9'h1FF, co: 1'b0, lo: 9'h1FF, ap: 1'b1, lp: 1'b1, z: 1'b0, pe: 1'b0});
    drive(9'h1FF, 9'h000, 1'b1, 2'b11, 2'b01);
    check_lit("pass_cout", '{ao: 9'h1FF, co: 1'b1, lo: 9'h1FF, ap: 1'b1, lp: 1'b1, z: 1'b0, pe: 1'b0});
    drive(9'h1FF, 9'h000, 1'b1, 2'b10, 2'b00);
    check_lit("inc_wrap", '{ao: 9'h000, co: 1'b1, lo: 9'h000, ap: 1'b0, lp: 1'b0, z: 1'b1, pe: 1'b0});

    for (int i = 0; i < 8; i++) drive_rand();
    rst = 1'b1;
    drive_rand();
    check_lit("mid_reset", '0);
    rst = 1'b0;

`ifdef C5315_PARITY_CHECK_EN
    drive(9'h001, 9'h000, 1'b0, 2'b00, 2'b00);
    bus.a_par_in = 1'b0;
    bus.b_par_in = 1'b0;
    @(negedge clk);
    check_lit("par_err_set", '{ao: 9'h001, co: 1'b0, lo: 9'h000, ap: 1'b1, lp: 1'b0, z: 1'b0, pe: 1'b1});
    bus.a_par_in = 1'b1;
    @(negedge clk);
    check_lit("par_err_clr", '{ao: 9'h001, co: 1'b0, lo: 9'h000, ap: 1'b1, lp: 1'b0, z: 1'b0, pe: 1'b0});
`endif

    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(40) == 0);
      drive_rand();
    end
    rst = 1'b0;
    drive_rand();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/c5315_alu_core.md
Name: c5315_alu_core

Overview:
- Registered 9-bit ALU datapath, functionally equivalent to the ISCAS-85 c5315 class of benchmark.
- Performs an arithmetic and a logic operation simultaneously on two 9-bit operands.
- Also produces the parity of each result and a zero flag.
- Used as a synthesizable aging/stress target: stimulus is applied every clock and results are sampled one cycle later.

Parameters:
- WIDTH, 9, operand and result width in bits; all behaviour below is specified for WIDTH=9 and must scale generically.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- cin  input  1  carry-in to the arithmetic unit
- arith_sel  input  2  arithmetic operation select
- logic_sel  input  2  logic operation select
- arith_out  output  WIDTH  registered arithmetic result
- cout  output  1  registered carry-out of the arithmetic unit
- logic_out  output  WIDTH  registered logic result
- arith_par  output  1  registered XOR-reduction of arith_out
- logic_par  output  1  registered XOR-reduction of logic_out
- zero  output  1  registered flag, 1 when the arithmetic result is all zeros

Behaviour:
- Single clock domain. All outputs are flops updated on the rising edge of clk. No combinational input-to-output path.
- Reset: when rst=1 at a rising edge, every output becomes 0, including zero and the parity bits. Reset overrides all inputs. Asserting rst mid-stream discards the in-flight result.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N. A new operation is accepted every cycle; there is no handshake and no stall.
- Arithmetic unit, computed at WIDTH+1 bits; {cout, arith_out} is the full sum:
  - arith_sel=00: a_in + b_in + cin
  - arith_sel=01: a_in + ~b_in + cin (a_in - b_in when cin=1; cout=1 means no borrow)
  - arith_sel=10: a_in + cin (pass or increment)
  - arith_sel=11: a_in + {WIDTH{1}} + cin (decrement when cin=0; pass with cout=1 when cin=1)
- Logic unit:
  - logic_sel=00: a_in & b_in
  - logic_sel=01: a_in | b_in
  - logic_sel=10: a_in ^ b_in
  - logic_sel=11: ~a_in
- Both units evaluate every cycle regardless of the other select.
- Parity outputs are computed from the next-state results, so they always match the registered values in the same cycle. A parity bit is 1 when the result has an odd number of ones.
- zero is computed from the arithmetic result only. cout does not affect zero.
- Wrap-around: the arithmetic result is truncated to WIDTH bits and the overflow goes to cout. There is no saturation.
- X on inputs while rst=1 must not propagate to the outputs.

Optional Feature:
- Macro: C5315_PARITY_CHECK_EN.
- When defined, the block adds three ports:
  - a_par_in (input, 1): even-parity bit for a_in, chosen so that ^{a_in,a_par_in}=0
  - b_par_in (input, 1): even-parity bit for b_in, same convention
  - par_err (output, 1): registered with 1-cycle latency; par_err = (^{a_in,a_par_in}) | (^{b_in,b_par_in}); reset value 0
- Results are still computed and registered when par_err=1.
- When not defined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset: drive rst=1 with random inputs for 2 cycles -> all outputs 0. Then release rst with a_in=0x003, b_in=0x004, arith_sel=00, logic_sel=10, cin=0 -> next cycle arith_out=0x007, cout=0, logic_out=0x007, arith_par=1, logic_par=1, zero=0.
- Add overflow: a_in=0x1FF, b_in=0x001, cin=0, arith_sel=00, logic_sel=00 -> arith_out=0x000, cout=1, zero=1, arith_par=0, logic_out=0x001, logic_par=1.
- Subtract: a_in=0x005, b_in=0x003, cin=1, arith_sel=01 -> arith_out=0x002, cout=1. Swap operands -> arith_out=0x1FE, cout=0.
- Decrement and invert: a_in=0x000, cin=0, arith_sel=11, logic_sel=11 -> arith_out=0x1FF, cout=0, arith_par=1, logic_out=0x1FF, logic_par=1.
- Back-to-back pipelining: apply 8 random vectors on consecutive cycles -> each output vector matches a reference model delayed exactly one cycle. Then assert rst mid-sequence -> outputs 0 on the following cycle.
- With C5315_PARITY_CHECK_EN defined: a_in=0x001, a_par_in=0, b_in=0x000, b_par_in=0 -> par_err=1 next cycle. Set a_par_in=1 -> par_err=0.
